// File: rtl/tile_probe.sv
// rtl/tile_probe.sv - four-corner tile map collision probe for one mover
//
// Reads the four corner tiles of a candidate object position, one corner per
// cycle, and classifies the move as free/blocked, reports goal tiles touched
// and the index of the first breakable tile hit.
//
// Ports:
//   Clk      system clock
//   Reset    synchronous, active-high reset
//   req      probe request, sampled only while idle
//   x, y     candidate top-left pixel position
//   map      tile map, row-major, index = row*COLS+col
//   busy     probe in progress (corner states and result strobe cycle)
//   done     one-cycle result strobe
//   free     no corner is blocking
//   hit_idx  index of first breakable corner tile, 0 = none
//   goal     bit0 = any corner code 3, bit1 = any corner code 4
module tile_probe #(
  parameter int TILE_W = 32,
  parameter int TILE_H = 32,
  parameter int COLS   = 20,
  parameter int ROWS   = 15,
  parameter int OBJ_W  = 32,
  parameter int OBJ_H  = 32
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       req,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  int         map [COLS*ROWS],
  output logic       busy,
  output logic       done,
  output logic       free,
  output int         hit_idx,
  output logic [1:0] goal
);

  localparam int SHX = $clog2(TILE_W);
  localparam int SHY = $clog2(TILE_H);
  localparam int IW  = $clog2(COLS*ROWS);
  localparam logic [10:0] XLIM = 11'(COLS*TILE_W);
  localparam logic [10:0] YLIM = 11'(ROWS*TILE_H);
  localparam logic [10:0] XOFF = 11'(OBJ_W-1);
  localparam logic [10:0] YOFF = 11'(OBJ_H-1);

  typedef enum logic [2:0] {IDLE, C0, C1, C2, C3, DONE} state_t;

  state_t      state, state_nxt;
  logic [9:0]  xl, yl;
  logic        blk_acc;
  logic        hit_found;
  logic        probing;

  logic [10:0]   px, py;
  logic          in_range;
  int            idx;
  logic [IW-1:0] idx_sel;
  int            tile;
  logic          c_blk, c_brk;
  logic [1:0]    c_goal;

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    probing   = 1'b0;
    case (state)
      IDLE:    if (req) state_nxt = C0;
      C0:      state_nxt = C1;
      C1:      state_nxt = C2;
      C2:      state_nxt = C3;
      C3:      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy    = (state != IDLE);
    done    = (state == DONE);
    probing = (state == C0) || (state == C1) || (state == C2) || (state == C3);
  end

  // Corner coordinates are 11 bits wide so x+OBJ_W-1 near 1023 cannot wrap
  // back into the map.
  always_comb begin
    px       = {1'b0, xl} + (((state == C1) || (state == C3)) ? XOFF : 11'd0);
    py       = {1'b0, yl} + (((state == C2) || (state == C3)) ? YOFF : 11'd0);
    in_range = (px < XLIM) && (py < YLIM);
    idx      = int'(py >> SHY) * COLS + int'(px >> SHX);
    // Out-of-range corners never look at the map; entry 0 is read but ignored.
    idx_sel  = in_range ? IW'(idx) : '0;
    tile     = map[idx_sel];
    c_blk    = 1'b1;
    c_brk    = 1'b0;
    c_goal   = 2'b00;
    if (in_range) begin
      case (tile)
        0, 6: c_blk = 1'b0;
        3: begin
          c_blk  = 1'b0;
          c_goal = 2'b01;
        end
        4: begin
          c_blk  = 1'b0;
          c_goal = 2'b10;
        end
        2:       c_brk = 1'b1;
        default: c_blk = 1'b1;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      xl        <= '0;
      yl        <= '0;
      blk_acc   <= 1'b0;
      hit_found <= 1'b0;
      free      <= 1'b0;
      hit_idx   <= 0;
      goal      <= 2'b00;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && req) begin
        xl        <= x;
        yl        <= y;
        blk_acc   <= 1'b0;
        hit_found <= 1'b0;
        free      <= 1'b0;
        hit_idx   <= 0;
        goal      <= 2'b00;
      end
      if (probing) begin
        blk_acc <= blk_acc | c_blk;
        goal    <= goal | c_goal;
        // First breakable corner wins; later ones leave hit_idx alone.
        if (c_brk && !hit_found) begin
          hit_idx   <= idx;
          hit_found <= 1'b1;
        end
        if (state == C3) free <= ~(blk_acc | c_blk);
      end
    end
  end

endmodule

// File: tb/tb_tile_probe.sv
// tb/tb_tile_probe.sv - directed vector bench for tile_probe
module tb_tile_probe;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       req = 1'b0;
  logic [9:0] x = '0;
  logic [9:0] y = '0;
  int         map [300];
  logic       busy, done, free;
  int         hit_idx;
  logic [1:0] goal;

  int total = 0;
  int bad   = 0;

  tile_probe dut (
    .Clk(Clk), .Reset(Reset), .req(req), .x(x), .y(y), .map(map),
    .busy(busy), .done(done), .free(free), .hit_idx(hit_idx), .goal(goal)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string      nm;
    int         px;
    int         py;
    int         ia;
    int         va;
    int         ib;
    int         vb;
    bit         f;
    int         h;
    logic [1:0] g;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Border tiles are solid (1), interior passable (0), plus up to two overrides.
  task automatic set_map(input int ia, input int va, input int ib, input int vb);
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 20; c++)
        map[r*20+c] = (r == 0 || r == 14 || c == 0 || c == 19) ? 1 : 0;
    if (ia >= 0) map[ia] = va;
    if (ib >= 0) map[ib] = vb;
  endtask

  task automatic run_probe(input vec_t v, input bit extra_req);
    int bc, dc, da;
    int fb;
    int f_at, h_at, g_at;
    bc = 0; dc = 0; da = -1; fb = 0; f_at = -1; h_at = -1; g_at = -1;
    set_map(v.ia, v.va, v.ib, v.vb);
    @(negedge Clk);
    x = 10'(v.px);
    y = 10'(v.py);
    req = 1'b1;
    @(posedge Clk);
    for (int i = 1; i <= 10; i++) begin
      if (i > 1) @(posedge Clk);
      #1;
      if (i == 1) req = 1'b0;
      if (i == 1) fb = int'(busy);
      if (busy) bc++;
      if (done) begin
        dc++;
        da = i;
        f_at = int'(free);
        h_at = hit_idx;
        g_at = int'(goal);
      end
      // Requests while busy (in a corner state and in DONE) must be dropped.
      if (extra_req && (i == 2 || i == 5)) req = 1'b1;
      if (extra_req && (i == 3 || i == 6)) req = 1'b0;
    end
    chk({v.nm, " busy_first"}, fb, 1);
    chk({v.nm, " busy_cycles"}, bc, 5);
    chk({v.nm, " done_pulses"}, dc, 1);
    chk({v.nm, " done_cycle"}, da, 5);
    chk({v.nm, " free"}, f_at, int'(v.f));
    chk({v.nm, " hit_idx"}, h_at, v.h);
    chk({v.nm, " goal"}, g_at, int'(v.g));
    chk({v.nm, " free_held"}, int'(free), int'(v.f));
    chk({v.nm, " hit_held"}, hit_idx, v.h);
    chk({v.nm, " goal_held"}, int'(goal), int'(v.g));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    vt[0] = '{"open",      32,   32,  -1, 0,  -1, 0, 1'b1, 0,   2'b00};
    vt[1] = '{"brk29",     272,  32,  29, 2,  -1, 0, 1'b0, 29,  2'b00};
    vt[2] = '{"goal3",     288,  416, 269, 3, -1, 0, 1'b1, 0,   2'b01};
    vt[3] = '{"right_oor", 620,  32,  -1, 0,  -1, 0, 1'b0, 0,   2'b00};
    vt[4] = '{"goal4",     48,   32,  22, 4,  -1, 0, 1'b1, 0,   2'b10};
    vt[5] = '{"two_brk",   48,   48,  41, 2,  42, 2, 1'b0, 41,  2'b00};
    vt[6] = '{"bot_oor",   64,   460, 282, 2, -1, 0, 1'b0, 282, 2'b00};
    vt[7] = '{"corner_max",1023, 1023, 0, 3,  -1, 0, 1'b0, 0,   2'b00};

    set_map(-1, 0, -1, 0);
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst free", int'(free), 0);
    chk("rst hit_idx", hit_idx, 0);
    chk("rst goal", int'(goal), 0);
    Reset = 1'b0;

    for (int i = 0; i < 8; i++) run_probe(vt[i], (i == 3));

    // Leave free=1/goal=01 held, then abort a probe with Reset at edge k+2.
    run_probe(vt[2], 1'b0);
    set_map(29, 2, -1, 0);
    @(negedge Clk);
    x = 10'd272;
    y = 10'd32;
    req = 1'b1;
    @(posedge Clk);
    #1 req = 1'b0;
    @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk);
    #1;
    chk("abort busy", int'(busy), 0);
    chk("abort free", int'(free), 0);
    chk("abort goal", int'(goal), 0);
    chk("abort hit_idx", hit_idx, 0);
    Reset = 1'b0;
    dc = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk);
      #1;
      if (done) dc++;
    end
    chk("abort no_done", dc, 0);
    run_probe(vt[1], 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
